// File: rtl/kuuga_bram_req_adapter.sv
// Core req/gnt/rvalid port onto a single-port BRAM with fixed read latency.
// Range-checks accesses and holds the BRAM output register in reset while flushing.
module kuuga_bram_req_adapter #(
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter logic [31:0] BASE_ADDR    = 32'h0,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned FLUSH_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_i,
  output logic                  gnt_o,
  input  logic [31:0]           addr_i,
  input  logic                  we_i,
  input  logic [3:0]            be_i,
  input  logic [31:0]           wdata_i,
  output logic                  rvalid_o,
  output logic [31:0]           rdata_o,
  output logic                  err_o,
  output logic                  bram_clk,
  output logic                  bram_rst,
  output logic                  bram_en,
  output logic [3:0]            bram_we,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [31:0]           bram_wrdata,
  input  logic [31:0]           bram_rddata
);

  localparam int unsigned CW  = $clog2(FLUSH_CYCLES) + 1;
  localparam logic [32:0] WIN = 33'd4 << ADDR_WIDTH;
  localparam int unsigned L   = READ_LATENCY;

  typedef enum logic {
    S_FLUSH,
    S_READY
  } state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;

  logic [L-1:0] vld_q, vld_d;
  logic [L-1:0] rd_q, rd_d;
  logic [L-1:0] er_q, er_d;

  logic [31:0] off;
  logic        inr;
  logic        acc;

  assign off = addr_i - BASE_ADDR;
  assign inr = {1'b0, off} < WIN;
  assign acc = req_i & ~reset & (state_q == S_READY);

  assign gnt_o       = acc;
  assign bram_clk    = clk;
  assign bram_rst    = reset | (state_q != S_READY);
  assign bram_en     = acc & inr;
  assign bram_we     = (acc & inr & we_i) ? be_i : 4'b0;
  assign bram_addr   = off[ADDR_WIDTH+1:2];
  assign bram_wrdata = wdata_i;

  // Response tag pipeline mirrors the BRAM read latency.
  always_comb begin
    vld_d    = vld_q << 1;
    rd_d     = rd_q << 1;
    er_d     = er_q << 1;
    vld_d[0] = acc;
    rd_d[0]  = acc & ~we_i;
    er_d[0]  = acc & ~inr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FLUSH;
      cnt_q   <= '0;
      vld_q   <= '0;
      rd_q    <= '0;
      er_q    <= '0;
    end else begin
      vld_q <= vld_d;
      rd_q  <= rd_d;
      er_q  <= er_d;
      unique case (state_q)
        S_FLUSH: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(FLUSH_CYCLES - 1))
            state_q <= S_READY;
        end
        S_READY: state_q <= S_READY;
        default: state_q <= S_FLUSH;
      endcase
    end
  end

  assign rvalid_o = vld_q[L-1] & ~reset;
  assign err_o    = rvalid_o & er_q[L-1];
  assign rdata_o  = (rvalid_o & rd_q[L-1] & ~er_q[L-1]) ?
                    bram_rddata : 32'h0;

endmodule
